// File: rtl/alu_pkg.sv
// ALU opcode encodings shared with ALU_control, plus the multiply sequencer state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_BLT  = 4'b1110;
    localparam logic [3:0] ALU_SLLI = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller that drives the shared external ALU (ADD / SLLI).
// Optional ALU_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    seq_state_t       state, state_nxt;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept = start && (state == ST_IDLE || state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_ADD;
            ST_ADD: begin
                state_nxt = ST_SHIFT;
`ifdef ALU_MUL_EARLY_EXIT_EN
                if (mplier == '0) state_nxt = ST_DONE;
`endif
            end
            ST_SHIFT: state_nxt = (cnt < LAST_ITER) ? ST_ADD : ST_DONE;
            ST_DONE:  state_nxt = start ? ST_ADD : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            if (accept) begin
                acc    <= '0;
                mcand  <= op_a;
                mplier <= op_b;
                cnt    <= '0;
            end else if (state == ST_ADD) begin
                if (mplier[0]) acc <= alu_result;
            end else if (state == ST_SHIFT) begin
                mcand  <= alu_result;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
            // acc is final on the cycle that leads into DONE (never accepted there)
            if (state_nxt == ST_DONE) product <= acc;
        end
    end

    always_comb begin
        busy    = (state == ST_ADD) || (state == ST_SHIFT);
        done    = (state == ST_DONE);
        alu_own = busy;
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = 4'b0000;
        case (state)
            ST_ADD: begin
`ifdef ALU_MUL_EARLY_EXIT_EN
                if (mplier != '0) begin
                    alu_a  = acc;
                    alu_b  = mcand;
                    alu_op = ALU_ADD;
                end
`else
                alu_a  = acc;
                alu_b  = mcand;
                alu_op = ALU_ADD;
`endif
            end
            ST_SHIFT: begin
                alu_a  = mcand;
                alu_b  = WIDTH'(1);
                alu_op = ALU_SLLI;
            end
            default: ;
        endcase
    end

endmodule
